// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: FSM state encoding used by
// the transmit arbiter, default bit timing for a 100 MHz clock at 9600 baud,
// and a helper that turns bit timing into a frame length in clock cycles.
// Also intended for use by top-level string sequencers.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } uart_state_t;

  localparam int DEFAULT_CYCLES_PER_BIT = 10416;  // 100 MHz / 9600 baud
  localparam int DEFAULT_BITS_PER_FRAME = 10;     // start + 8 data + stop

  // Number of clock cycles one complete UART frame occupies on the line
  function automatic int frame_cycles(input int cycles_per_bit, input int bits_per_frame);
    return cycles_per_bit * bits_per_frame;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority picker. Searches the request vector upward
// from the start index, wrapping at N, and returns the first set request.
// Ports:
//   req        in   N   request vector
//   start      in   W   index given top priority (must be < N)
//   grant      out  N   one-hot grant (all zero when no request)
//   grant_idx  out  W   index of the granted request (0 when no request)
//   any_req    out  1   at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_req
);

  // Walk the requests starting at 'start'; the first hit wins
  always_comb begin
    int          idx;
    logic [W-1:0] idx_w;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int off = 0; off < N; off++) begin
      idx   = (int'(start) + off) % N;
      idx_w = W'(idx);
      if (!any_req && req[idx_w]) begin
        any_req        = 1'b1;
        grant[idx_w]   = 1'b1;
        grant_idx      = idx_w;
      end else begin
        any_req        = any_req;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_send transmitter among NUM_REQ byte requesters. A byte is
// granted round-robin, latched, announced with a one-cycle tx_valid pulse and
// then the arbiter waits out one full frame time, because uart_send offers no
// busy indication of its own.
//
// Optional feature (macro UART_ARB_LOCK_EN): adds input req_last. A captured
// byte with req_last[i]=0 locks the grant to requester i until a byte with
// req_last[i]=1 has been sent, keeping multi-byte strings contiguous.
//
// Ports:
//   clk        in   1               system clock
//   rst        in   1               asynchronous reset, active-high
//   req_valid  in   NUM_REQ         requester i has a byte pending
//   req_data   in   8*NUM_REQ       byte of requester i at [8*i+7:8*i]
//   req_last   in   NUM_REQ         (UART_ARB_LOCK_EN only) last byte of string
//   req_ack    out  NUM_REQ         one-cycle pulse: byte of requester i taken
//   tx_data    out  8               byte for uart_send, stable through frame
//   tx_valid   out  1               one-cycle send strobe for uart_send
//   grant_id   out  clog2(NUM_REQ)  index of the last granted requester
//   busy       out  1               high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  parameter int BITS_PER_FRAME = DEFAULT_BITS_PER_FRAME
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_last,
`endif
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int FRAME_CYCLES = frame_cycles(CYCLES_PER_BIT, BITS_PER_FRAME);
  localparam int CNT_W        = $clog2(FRAME_CYCLES);
  localparam int ID_W         = $clog2(NUM_REQ);

  uart_state_t          state_r, state_n;
  logic [CNT_W-1:0]     frame_cnt_r, frame_cnt_n;
  logic [7:0]           tx_data_r, tx_data_n;
  logic                 tx_valid_r, tx_valid_n;
  logic [NUM_REQ-1:0]   req_ack_r, req_ack_n;
  logic [ID_W-1:0]      grant_id_r, grant_id_n;
  logic                 busy_r;
  // Start index for the next search; kept apart from grant_id so that
  // requester 0 has top priority after reset while grant_id still reads 0.
  logic [ID_W-1:0]      ptr_r, ptr_n;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   win_oh;
  logic [ID_W-1:0]      win_idx;
  logic                 win_any;
  logic [7:0]           win_data;

`ifdef UART_ARB_LOCK_EN
  logic                 lock_r, lock_n;
  logic [ID_W-1:0]      lock_id_r, lock_id_n;

  // While locked only the owner may be granted; everybody else waits
  always_comb begin
    if (lock_r) begin
      eligible = req_valid & (NUM_REQ'(1) << lock_id_r);
    end else begin
      eligible = req_valid;
    end
  end
`else
  // Every byte is arbitrated among all valid requesters
  always_comb begin
    eligible = req_valid;
  end
`endif

  rr_arbiter #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr_arbiter (
    .req       (eligible),
    .start     (ptr_r),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .any_req   (win_any)
  );

  // AND-OR mux of the winning requester's byte
  always_comb begin
    win_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_data = win_data | (req_data[8*i +: 8] & {8{win_oh[i]}});
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state_r;
    frame_cnt_n = frame_cnt_r;
    tx_data_n   = tx_data_r;
    tx_valid_n  = 1'b0;
    req_ack_n   = '0;
    grant_id_n  = grant_id_r;
    ptr_n       = ptr_r;
`ifdef UART_ARB_LOCK_EN
    lock_n      = lock_r;
    lock_id_n   = lock_id_r;
`endif
    case (state_r)
      IDLE: begin
        if (win_any) begin
          state_n    = SEND;
          tx_data_n  = win_data;
          grant_id_n = win_idx;
          tx_valid_n = 1'b1;
          req_ack_n  = win_oh;
          ptr_n      = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
`ifdef UART_ARB_LOCK_EN
          // A non-final byte (re)locks to its owner; a final byte releases
          lock_n     = ~req_last[win_idx];
          lock_id_n  = win_idx;
`endif
        end else begin
          state_n    = IDLE;
        end
      end
      SEND: begin
        state_n     = WAIT;
        frame_cnt_n = '0;
      end
      WAIT: begin
        if (frame_cnt_r == CNT_W'(FRAME_CYCLES - 1)) begin
          state_n     = IDLE;
          frame_cnt_n = '0;
        end else begin
          frame_cnt_n = frame_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_n     = IDLE;
        frame_cnt_n = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      frame_cnt_r <= '0;
      tx_data_r   <= 8'h00;
      tx_valid_r  <= 1'b0;
      req_ack_r   <= '0;
      grant_id_r  <= '0;
      busy_r      <= 1'b0;
      ptr_r       <= '0;
    end else begin
      state_r     <= state_n;
      frame_cnt_r <= frame_cnt_n;
      tx_data_r   <= tx_data_n;
      tx_valid_r  <= tx_valid_n;
      req_ack_r   <= req_ack_n;
      grant_id_r  <= grant_id_n;
      busy_r      <= (state_n != IDLE);
      ptr_r       <= ptr_n;
    end
  end

`ifdef UART_ARB_LOCK_EN
  // Lock ownership register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_r    <= 1'b0;
      lock_id_r <= '0;
    end else begin
      lock_r    <= lock_n;
      lock_id_r <= lock_id_n;
    end
  end
`endif

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign req_ack  = req_ack_r;
  assign grant_id = grant_id_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with NUM_REQ=4, CYCLES_PER_BIT=4,
// BITS_PER_FRAME=10 (40-cycle frames, 42-cycle byte spacing). Expected bytes
// are queued when stimulus is set up and checked by a monitor at each
// tx_valid pulse. Honours UART_ARB_LOCK_EN for the string-lock scenario.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int SPACING = 42;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [3:0]      req_valid;
  logic [31:0]     req_data;
`ifdef UART_ARB_LOCK_EN
  logic [3:0]      req_last;
`endif
  logic [3:0]      req_ack;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic [1:0]      grant_id;
  logic            busy;

  exp_t            sb_q[$];
  exp_t            mon_e;
  logic [3:0]      mon_oh;
  int              vectors;
  int              miscompares;
  int              cyc;

  uart_tx_arbiter #(
    .NUM_REQ        (NREQ),
    .CYCLES_PER_BIT (4),
    .BITS_PER_FRAME (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_last  (req_last),
`endif
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every tx_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && tx_valid) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e  = sb_q.pop_front();
        mon_oh = 4'b0001 << mon_e.id;
        chk("tx_data", 32'(tx_data), 32'(mon_e.data));
        chk("grant_id", 32'(grant_id), 32'(mon_e.id));
        chk("req_ack", 32'(req_ack), 32'(mon_oh));
      end
    end
  end

  task automatic push(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic wait_tx(output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tx_pulse_seen", 32'(tx_valid), 32'd1);
    at = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("return_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
`ifdef UART_ARB_LOCK_EN
    req_last  = 4'b1111;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
    chk({tag, "_req_ack"},  32'(req_ack),  32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
  endtask

  initial begin
    int t0, t1, t2;
    int sent0;
    int npulse;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;

    // 1: reset values, then 100 idle cycles without requests
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
`ifdef UART_ARB_LOCK_EN
    req_last  = 4'b1111;
`endif
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_quiet", {30'd0, busy, tx_valid}, 32'd0);
    end

    // 2: single requester held valid gets every slot, 42 cycles apart
    req_data[7:0] = 8'h68;
    req_valid     = 4'b0001;
    push(2'd0, 8'h68);
    push(2'd0, 8'h68);
    push(2'd0, 8'h68);
    wait_tx(t0);
    wait_tx(t1);
    chk("spacing_1", 32'(t1 - t0), 32'(SPACING));
    wait_tx(t2);
    chk("spacing_2", 32'(t2 - t1), 32'(SPACING));
    req_valid = 4'b0000;
    wait_idle();

    // 3: all valid -> 0,1,2,3,0
    do_reset();
    req_data  = 32'h33323130;
    req_valid = 4'b1111;
    push(2'd0, 8'h30);
    push(2'd1, 8'h31);
    push(2'd2, 8'h32);
    push(2'd3, 8'h33);
    push(2'd0, 8'h30);
    for (int i = 0; i < 5; i++) wait_tx(t0);
    req_valid = 4'b0000;
    wait_idle();

    // 4: request during WAIT is held, withdrawn request is never acked
    do_reset();
    req_data[7:0] = 8'h41;
    req_valid     = 4'b0001;
    push(2'd0, 8'h41);
    push(2'd1, 8'h42);
    wait_tx(t0);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    req_data[15:8] = 8'h42;
    req_valid      = 4'b0010;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("no_ack_in_wait", 32'(req_ack), 32'd0);
    end
    wait_tx(t1);
    chk("held_req_spacing", 32'(t1 - t0), 32'(SPACING));
    req_valid = 4'b0000;
    wait_idle();
    repeat (50) @(negedge clk);

    // 5: reset in the middle of WAIT, then requester 0 wins over 2
    do_reset();
    req_data[7:0] = 8'h55;
    req_valid     = 4'b0001;
    push(2'd0, 8'h55);
    wait_tx(t0);
    req_valid = 4'b0000;
    repeat (11) @(negedge clk);
    chk("mid_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    req_data  = 32'h00620060;
    req_valid = 4'b0101;
    push(2'd0, 8'h60);
    @(negedge clk);
    rst = 1'b0;
    wait_tx(t0);
    req_valid = 4'b0000;
    wait_idle();

    // 6: three-byte string from requester 0 against requester 2
    do_reset();
    req_data  = 32'h00C000A0;
`ifdef UART_ARB_LOCK_EN
    req_last  = 4'b1110;
    push(2'd0, 8'hA0);
    push(2'd0, 8'hA1);
    push(2'd0, 8'hA2);
    push(2'd2, 8'hC0);
    npulse = 4;
`else
    push(2'd0, 8'hA0);
    push(2'd2, 8'hC0);
    push(2'd0, 8'hA1);
    push(2'd2, 8'hC0);
    push(2'd0, 8'hA2);
    npulse = 5;
`endif
    req_valid = 4'b0101;
    sent0     = 0;
    for (int i = 0; i < npulse; i++) begin
      wait_tx(t0);
      if (req_ack[0]) begin
        sent0++;
        if (sent0 < 3) begin
          req_data[7:0] = 8'hA0 + 8'(sent0);
`ifdef UART_ARB_LOCK_EN
          req_last[0]   = (sent0 == 2);
`endif
        end else begin
          req_valid[0] = 1'b0;
        end
      end else begin
        sent0 = sent0;
      end
    end
    req_valid = 4'b0000;
    wait_idle();
    repeat (50) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
